fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  memory returns imem_rdata for the outstanding request this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 PCSrc  input  1  redirect strobe from the controller's condition logic.
REQ-010 PCTarget  input  32  redirect address, valid when PCSrc=1.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready  input  1  decode consumes the head this cycle.
REQ-013 Instr  output  32  head instruction word.
REQ-014 PC  output  32  address of the head instruction.
REQ-015 PCPlus8  output  32  PC+8 (ARM read-PC value), combinational from PC.

Function
REQ-016 The FSM SHALL have states IDLE (no request outstanding), WAIT (request outstanding) and DROP (outstanding response to be discarded).
REQ-017 In IDLE, imem_req SHALL assert with imem_addr=fetch_pc when buffer occupancy < DEPTH; the state SHALL move to WAIT.
REQ-018 In WAIT, imem_req and imem_addr SHALL hold stable until imem_ack; at most one request SHALL be outstanding.
REQ-019 On imem_ack in WAIT, {fetch_pc, imem_rdata} SHALL be enqueued, fetch_pc SHALL advance by 4 (mod 2^32, wrapping 32'hFFFF_FFFC to 0), and the state SHALL return to IDLE.
REQ-020 A request in IDLE SHALL be issued only when a slot is free; an enqueue SHALL never overflow.
REQ-021 Dequeue SHALL occur when instr_valid && instr_ready; enqueue and dequeue in the same cycle SHALL leave occupancy unchanged.
REQ-022 Instr/PC SHALL be undefined-safe (hold last head) but qualified only by instr_valid; instr_valid=0 when empty.
REQ-023 On PCSrc=1, the buffer SHALL flush, fetch_pc SHALL load {PCTarget[31:2],2'b00}, and instr_valid SHALL be 0 the next cycle.
REQ-024 On PCSrc=1 in WAIT without imem_ack, the state SHALL go to DROP; in DROP imem_req SHALL stay asserted with the old address until imem_ack, then the data SHALL be discarded and the state SHALL go to IDLE.
REQ-025 On PCSrc=1 coincident with imem_ack, the returned word SHALL be discarded, the state SHALL go to IDLE, and redirect SHALL take priority over enqueue and dequeue.
REQ-026 A further PCSrc in DROP SHALL update fetch_pc only; the state SHALL remain DROP.
REQ-027 Best-case redirect-to-instr_valid latency SHALL be 2 cycles with a zero-wait memory.

Reset
REQ-028 reset SHALL set state=IDLE, fetch_pc=RESET_VECTOR, occupancy=0, instr_valid=0, imem_req=0, PC=RESET_VECTOR, Instr=0.
REQ-029 reset asserted mid-request SHALL abandon the outstanding transaction; the memory SHALL treat imem_req deassertion as a cancel.
REQ-030 imem_req SHALL first assert in the cycle after reset deasserts.

Structure
REQ-031 The FSM state encoding and RESET_VECTOR default SHALL live in the shared CPU package.
REQ-032 The buffer SHALL be a sub-module fetch_fifo (DEPTH entries of 64 bits, flush input); the FSM and PC logic SHALL stay in fetch_unit.

Verification
REQ-033 Reset release, zero-wait memory returning 32'hE3A0_0001 at address 0 -> imem_addr 0,4,8...; Instr=32'hE3A0_0001, PC=0, PCPlus8=8.
REQ-034 instr_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_req low, no data lost on release.
REQ-035 PCSrc=1, PCTarget=32'h0000_0100 while WAIT with 3-cycle memory latency -> DROP, old word discarded, next enqueued PC=0x100.
REQ-036 PCSrc=1 coincident with imem_ack -> word dropped, next imem_addr=PCTarget.
REQ-037 fetch_pc=32'hFFFF_FFFC -> next imem_addr=0.
REQ-038 reset pulsed during WAIT -> imem_req=0 next cycle, then fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: FSM encoding,
// default reset vector and word-alignment helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned FETCH_DEPTH_DEFAULT  = 2;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} pairs. Flush empties it in one cycle;
// when empty the head output keeps showing the last valid head.
module fetch_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter logic [63:0] RESET_HEAD = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [63:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [63:0]   last;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= RESET_HEAD;
    end else begin
      if (!empty) last <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory request FSM, fetch PC with
// redirect handling, and a small decoupling buffer toward decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned DEPTH        = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_addr;
  logic         fifo_full;
  logic         fifo_empty;
  logic         enq;
  logic         deq;
  logic [63:0]  head;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A request issued from IDLE may be acked in the same cycle (zero-wait
  // memory); only an un-acked issue moves on to WAIT, or DROP if redirected.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (!fifo_full && !imem_ack) state_next = PCSrc ? DROP : WAIT;
      WAIT: begin
        if (imem_ack)   state_next = IDLE;
        else if (PCSrc) state_next = DROP;
      end
      DROP: if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = req_addr;
    enq       = 1'b0;
    unique case (state)
      IDLE: begin
        imem_req  = !fifo_full;
        imem_addr = fetch_pc;
        enq       = !fifo_full && imem_ack && !PCSrc;
      end
      WAIT: begin
        imem_req = 1'b1;
        enq      = imem_ack && !PCSrc;
      end
      DROP: imem_req = 1'b1;
      default: ;
    endcase
    if (reset) begin
      imem_req = 1'b0;
      enq      = 1'b0;
    end
  end

  // req_addr freezes the issued address so DROP keeps presenting it after
  // fetch_pc has already moved to the redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_VECTOR;
      req_addr <= RESET_VECTOR;
    end else begin
      if (state == IDLE) req_addr <= fetch_pc;
      if (PCSrc)         fetch_pc <= align_word(PCTarget);
      else if (enq)      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  assign deq = instr_valid && instr_ready && !PCSrc;

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .RESET_HEAD ({RESET_VECTOR, 32'h0000_0000})
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (PCSrc),
    .push      (enq),
    .push_data ({imem_addr, imem_rdata}),
    .pop       (deq),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign instr_valid = !fifo_empty;
  assign PC          = head[63:32];
  assign Instr       = head[31:0];
  assign PCPlus8     = PC + 32'd8;

endmodule
